// File: rtl/ysyx_22041405_mem_arbiter_pkg.sv
// Shared definitions for the IF/LS memory arbiter: FSM state encoding and requester IDs.
package ysyx_22041405_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/ysyx_22041405_rr_arb2.sv
// Two-way round-robin arbiter: grant is one-hot {LS, IF}; last_grant advances on accept.
module ysyx_22041405_rr_arb2
  import ysyx_22041405_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = req;
    if (&req) begin
      grant = (last_grant == REQ_IF) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ_IF;
    end else if (accept && (|grant)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/ysyx_22041405_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
module ysyx_22041405_mem_arbiter
  import ysyx_22041405_mem_arbiter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MASK_W = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [WIDTH-1:0]  if_addr,
  output logic              if_rsp_valid,
  output logic [WIDTH-1:0]  if_rsp_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_we,
  input  logic [WIDTH-1:0]  ls_addr,
  input  logic [WIDTH-1:0]  ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_rsp_valid,
  output logic [WIDTH-1:0]  ls_rsp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [WIDTH-1:0]  mem_rdata
);

  state_t             state_q, state_d;
  logic [1:0]         grant;
  logic               accept;
  logic               owner_q;
  logic               we_q;
  logic [WIDTH-1:0]   addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic [MASK_W-1:0]  mask_q;

  ysyx_22041405_rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    ({ls_req_valid, if_req_valid}),
    .accept (accept),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Readies are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          if_req_ready = grant[0];
          ls_req_ready = grant[1];
          accept       = |grant;
        end
        if (accept) state_d = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = RSP;
      end
      RSP: begin
        if (mem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we    = mem_req_valid & we_q;
  assign mem_addr  = mem_req_valid ? addr_q  : '0;
  assign mem_wdata = mem_req_valid ? wdata_q : '0;
  assign mem_wmask = mem_req_valid ? mask_q  : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= REQ_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else if (accept) begin
      owner_q <= grant[1];
      we_q    <= grant[1] & ls_we;
      addr_q  <= grant[1] ? ls_addr  : if_addr;
      wdata_q <= grant[1] ? ls_wdata : '0;
      mask_q  <= (grant[1] && ls_we) ? ls_wmask : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if_rsp_rdata <= '0;
      ls_rsp_rdata <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if ((state_q == RSP) && mem_rsp_valid) begin
        if (owner_q == REQ_LS) begin
          ls_rsp_valid <= 1'b1;
          ls_rsp_rdata <= mem_rdata;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041405_mem_arbiter.sv
// Bench for the IF/LS memory arbiter: transaction-level model checked every cycle plus directed cases.
module tb_ysyx_22041405_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr, if_rsp_rdata;
  logic        ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid;
  logic [31:0] ls_addr, ls_wdata, ls_rsp_rdata;
  logic [3:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_22041405_mem_arbiter #(.WIDTH(32), .MASK_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  // Transaction-level model: one outstanding transaction, owner, payload, and who was served last.
  bit          m_busy, m_issued, m_owner_ls, m_we, m_last_ls;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_mask;
  bit          e_if_v, e_ls_v;
  logic [31:0] e_if_d, e_ls_d;
  bit          x_if_rdy, x_ls_rdy;

  logic        s_if_rdy, s_ls_rdy, s_mrv, s_mwe, s_if_v, s_ls_v;
  logic [31:0] s_maddr, s_mwdata, s_if_d, s_ls_d;
  logic [3:0]  s_mmask;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_owner_ls = 0; m_we = 0; m_last_ls = 0;
    m_addr = '0; m_wdata = '0; m_mask = '0;
    e_if_v = 0; e_ls_v = 0; e_if_d = '0; e_ls_d = '0;
  endtask

  task automatic compare();
    if (rst) model_reset();
    x_if_rdy = !rst && !m_busy && if_req_valid && (!ls_req_valid || m_last_ls);
    x_ls_rdy = !rst && !m_busy && ls_req_valid && (!if_req_valid || !m_last_ls);
    chk("if_req_ready", {31'd0, if_req_ready}, {31'd0, x_if_rdy});
    chk("ls_req_ready", {31'd0, ls_req_ready}, {31'd0, x_ls_rdy});
    chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, m_busy && !m_issued});
    if (m_busy && !m_issued) begin
      chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, m_mask});
      if (m_owner_ls) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (rst) begin
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    end
    chk("if_rsp_valid", {31'd0, if_rsp_valid}, {31'd0, e_if_v});
    chk("ls_rsp_valid", {31'd0, ls_rsp_valid}, {31'd0, e_ls_v});
    chk("if_rsp_rdata", if_rsp_rdata, e_if_d);
    chk("ls_rsp_rdata", ls_rsp_rdata, e_ls_d);
    chk("rsp_exclusive", {31'd0, if_rsp_valid & ls_rsp_valid}, 32'd0);
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    e_if_v = 0;
    e_ls_v = 0;
    if (!m_busy) begin
      if (x_if_rdy || x_ls_rdy) begin
        m_owner_ls = x_ls_rdy;
        m_last_ls  = x_ls_rdy;
        m_we       = x_ls_rdy && ls_we;
        m_addr     = x_ls_rdy ? ls_addr : if_addr;
        m_wdata    = ls_wdata;
        m_mask     = (x_ls_rdy && ls_we) ? ls_wmask : 4'd0;
        m_busy     = 1;
        m_issued   = 0;
      end
    end else if (!m_issued) begin
      if (mem_req_ready) m_issued = 1;
    end else if (mem_rsp_valid) begin
      m_busy = 0;
      if (m_owner_ls) begin e_ls_v = 1; e_ls_d = mem_rdata; end
      else            begin e_if_v = 1; e_if_d = mem_rdata; end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    s_if_rdy = if_req_ready; s_ls_rdy = ls_req_ready; s_mrv = mem_req_valid;
    s_mwe = mem_we; s_maddr = mem_addr; s_mwdata = mem_wdata; s_mmask = mem_wmask;
    s_if_v = if_rsp_valid; s_if_d = if_rsp_rdata; s_ls_v = ls_rsp_valid; s_ls_d = ls_rsp_rdata;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    if_req_valid = 0; ls_req_valid = 0; mem_req_ready = 1; mem_rsp_valid = 1;
    for (int i = 0; i < n; i++) step();
    mem_rsp_valid = 0;
  endtask

  int seq[$];

  initial begin
    model_reset();
    rst = 1;
    if_req_valid = 0; if_addr = '0;
    ls_req_valid = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    step(); step();
    chk("reset_mem_req_valid", {31'd0, s_mrv}, 32'd0);
    rst = 0;

    // IF-only read with 1-cycle memory
    if_req_valid = 1; if_addr = 32'h8000_0000; mem_req_ready = 1;
    step();
    chk("t1_if_ready_c0", {31'd0, s_if_rdy}, 32'd1);
    if_req_valid = 0;
    step();
    chk("t1_mrv_c1", {31'd0, s_mrv}, 32'd1);
    chk("t1_addr_c1", s_maddr, 32'h8000_0000);
    mem_rsp_valid = 1; mem_rdata = 32'h0000_0413;
    step();
    mem_rsp_valid = 0;
    step();
    chk("t1_if_rsp_c3", {31'd0, s_if_v}, 32'd1);
    chk("t1_if_data_c3", s_if_d, 32'h0000_0413);
    chk("t1_ls_rsp_c3", {31'd0, s_ls_v}, 32'd0);

    // Contention out of reset: LS, IF, LS, IF
    rst = 1; step(); rst = 0;
    if_req_valid = 1; ls_req_valid = 1; ls_we = 0; ls_addr = 32'h8000_0040;
    mem_req_ready = 1; mem_rsp_valid = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_ls_rdy) seq.push_back(1);
      if (s_if_rdy) seq.push_back(0);
    end
    chk("t2_grant_count", seq.size(), 32'd4);
    for (int i = 0; i < 4 && i < seq.size(); i++)
      chk("t2_rr_order", seq[i], (i % 2 == 0) ? 32'd1 : 32'd0);
    drain(4);

    // LS write with stalled mem_req_ready and spurious responses in REQ
    ls_req_valid = 1; ls_we = 1; ls_addr = 32'h8000_0100; ls_wdata = 32'hDEAD_BEEF;
    ls_wmask = 4'b0011; mem_req_ready = 0; mem_rsp_valid = 0;
    step();
    chk("t3_ls_ready", {31'd0, s_ls_rdy}, 32'd1);
    ls_req_valid = 0; ls_wdata = 32'h0; ls_addr = 32'h0; ls_wmask = 4'hf;
    mem_rsp_valid = 1;
    for (int c = 0; c < 4; c++) begin
      mem_req_ready = (c == 3);
      step();
      chk("t3_mrv", {31'd0, s_mrv}, 32'd1);
      chk("t3_we", {31'd0, s_mwe}, 32'd1);
      chk("t3_addr", s_maddr, 32'h8000_0100);
      chk("t3_wdata", s_mwdata, 32'hDEAD_BEEF);
      chk("t3_mask", {28'd0, s_mmask}, 32'd3);
      chk("t3_no_rsp", {31'd0, s_ls_v}, 32'd0);
    end
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
    step();
    chk("t3_rsp_wait", {31'd0, s_ls_v}, 32'd0);
    mem_rsp_valid = 0;
    step();
    chk("t3_ls_rsp", {31'd0, s_ls_v}, 32'd1);
    chk("t3_ls_data", s_ls_d, 32'h1234_5678);

    // LS read forces mask and we low
    ls_req_valid = 1; ls_we = 0; ls_wmask = 4'b1111; ls_addr = 32'h8000_0200;
    mem_req_ready = 1;
    step();
    ls_req_valid = 0;
    step();
    chk("t4_mrv", {31'd0, s_mrv}, 32'd1);
    chk("t4_we", {31'd0, s_mwe}, 32'd0);
    chk("t4_mask", {28'd0, s_mmask}, 32'd0);
    drain(3);

    // Spurious response in IDLE
    mem_rsp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
    step(); step();
    chk("t5_if_rsp", {31'd0, s_if_v}, 32'd0);
    chk("t5_ls_rsp", {31'd0, s_ls_v}, 32'd0);
    mem_rsp_valid = 0;

    // Reset while in RSP
    if_req_valid = 1; if_addr = 32'h8000_0300; mem_req_ready = 1;
    step();
    if_req_valid = 0;
    step();
    rst = 1; if_req_valid = 1; ls_req_valid = 1;
    step();
    chk("t6_rst_if_rdy", {31'd0, s_if_rdy}, 32'd0);
    chk("t6_rst_ls_rdy", {31'd0, s_ls_rdy}, 32'd0);
    chk("t6_rst_mrv", {31'd0, s_mrv}, 32'd0);
    chk("t6_rst_if_d", s_if_d, 32'd0);
    chk("t6_rst_ls_d", s_ls_d, 32'd0);
    rst = 0; if_req_valid = 0; ls_req_valid = 0; mem_rsp_valid = 1;
    step(); step();
    chk("t6_no_if_rsp", {31'd0, s_if_v}, 32'd0);
    chk("t6_no_ls_rsp", {31'd0, s_ls_v}, 32'd0);
    mem_rsp_valid = 0; if_req_valid = 1; ls_req_valid = 1;
    step();
    chk("t6_tie_ls", {31'd0, s_ls_rdy}, 32'd1);
    chk("t6_tie_if", {31'd0, s_if_rdy}, 32'd0);
    drain(4);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      if_req_valid  = $urandom_range(0, 1);
      if_addr       = $urandom;
      ls_req_valid  = $urandom_range(0, 1);
      ls_we         = $urandom_range(0, 1);
      ls_addr       = $urandom;
      ls_wdata      = $urandom;
      ls_wmask      = 4'($urandom);
      mem_req_ready = $urandom_range(0, 1);
      mem_rsp_valid = ($urandom_range(0, 9) < 3);
      mem_rdata     = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
